tiq_adc_seq_ctrl: RTL and testbench

//   Conversion sequencer for the on-chip TIQ (inverter-threshold) flash ADC.
//   - Powers the comparator bank, waits for it to settle, then synchronises its thermometer code.
//   - Decodes the code to binary and averages 2^AVG_LOG2 samples.
//   - Presents each result on a valid/ready port; sits between the analog macro and the uo_out/uio pins.
//   - Supports single-shot conversions and periodic free-running conversions.

---
 rtl/tiq_adc_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_tiq_adc_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tiq_adc_seq_ctrl.sv
// Conversion sequencer for the TIQ flash ADC: settle, synchronise, decode, average, valid/ready output.
// Optional bubble correction stage enabled by defining TIQ_BUBBLE_CORR_EN.
module tiq_adc_seq_ctrl #(
    parameter int THERM_W    = 15,
    parameter int OUT_W      = 4,
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               cont_mode,
    input  logic [7:0]         period,
    input  logic [THERM_W-1:0] therm_in,
    output logic               sample_en,
    output logic [OUT_W-1:0]   result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy,
    output logic               overrun
);

    localparam int ACC_W = OUT_W + AVG_LOG2;
    localparam int CNT_W = (SETTLE_CYC > 256) ? $clog2(SETTLE_CYC) : 8;
`ifdef TIQ_BUBBLE_CORR_EN
    localparam int SYNC_CYC = 3;
`else
    localparam int SYNC_CYC = 2;
`endif
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LAST    = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SYNC,
        ST_ACC,
        ST_DONE,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sample_en_q, sample_en_d;
    logic [OUT_W-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic [THERM_W-1:0] sync1_q, sync2_q, code_src;
    logic [OUT_W-1:0]   decoded;

    function automatic logic [OUT_W-1:0] therm_decode(input logic [THERM_W-1:0] t);
        logic [OUT_W-1:0] code;
        logic             stop;
        code = '0;
        stop = 1'b0;
        for (int unsigned i = 0; i < THERM_W; i++) begin
            if (!stop) begin
                if (t[i]) code = code + OUT_W'(1);
                else      stop = 1'b1;
            end
        end
        return code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= therm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef TIQ_BUBBLE_CORR_EN
    // Padded with a virtual 1 below bit 0 and a virtual 0 above the top bit.
    function automatic logic [THERM_W-1:0] bubble_fix(input logic [THERM_W-1:0] t);
        logic [THERM_W+1:0] ext;
        logic [THERM_W-1:0] r;
        ext = {1'b0, t, 1'b1};
        r   = '0;
        for (int unsigned i = 0; i < THERM_W; i++) begin
            r[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        return r;
    endfunction

    logic [THERM_W-1:0] corr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) corr_q <= '0;
        else        corr_q <= bubble_fix(sync2_q);
    end

    assign code_src = corr_q;
`else
    assign code_src = sync2_q;
`endif

    assign decoded = therm_decode(code_src);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sample_en_d = sample_en_q;
        result_d    = result_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        if (valid_q && result_ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (!ena) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            sample_en_d = 1'b0;
            valid_d     = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start || cont_mode) begin
                        state_d     = ST_SETTLE;
                        cnt_d       = SETTLE_LAST;
                        sample_en_d = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SYNC;
                        cnt_d   = SYNC_LAST;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SYNC: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ACC;
                        cnt_d   = ACC_LAST;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ACC: begin
                    acc_d = acc_q + ACC_W'(decoded);
                    if (cnt_q == '0) state_d = ST_DONE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_DONE: begin
                    // A simultaneous handshake consumes the old result without touching overrun.
                    result_d    = OUT_W'(acc_q >> AVG_LOG2);
                    valid_d     = 1'b1;
                    overrun_d   = (valid_q && !result_ready) ? 1'b1 : overrun_q;
                    sample_en_d = 1'b0;
                    acc_d       = '0;
                    if (cont_mode) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(period);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT: begin
                    if (!cont_mode) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d     = ST_SETTLE;
                        cnt_d       = SETTLE_LAST;
                        sample_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    acc_d       = '0;
                    sample_en_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sample_en_q <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sample_en_q <= sample_en_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign sample_en    = sample_en_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tiq_adc_seq_ctrl.sv
// Self-checking bench for tiq_adc_seq_ctrl: directed scenarios plus randomized comparator codes
// compared against a behavioural model of the decode/average/handshake rules.
module tb_tiq_adc_seq_ctrl;

    localparam int THERM_W    = 15;
    localparam int OUT_W      = 4;
    localparam int SETTLE_CYC = 4;
    localparam int AVG_LOG2   = 2;
    localparam int NAVG       = 1 << AVG_LOG2;
`ifdef TIQ_BUBBLE_CORR_EN
    localparam int LAT      = SETTLE_CYC + 3 + NAVG + 1;
    localparam int EXP_BUBB = 5;
`else
    localparam int LAT      = SETTLE_CYC + 2 + NAVG + 1;
    localparam int EXP_BUBB = 4;
`endif
    // First averaged comparator sample is the one present at edge T+SETTLE_CYC+1.
    localparam int WIN      = SETTLE_CYC + 1;
    localparam int PER      = 3;
    localparam int SPAN     = LAT + PER;

    logic               clk = 1'b0;
    logic               rst_n, ena, start, cont_mode, result_ready;
    logic [7:0]         period;
    logic [THERM_W-1:0] therm_in;
    logic               sample_en, result_valid, busy, overrun;
    logic [OUT_W-1:0]   result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [THERM_W-1:0] hist [0:1023];

    tiq_adc_seq_ctrl #(
        .THERM_W    (THERM_W),
        .OUT_W      (OUT_W),
        .SETTLE_CYC (SETTLE_CYC),
        .AVG_LOG2   (AVG_LOG2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .cont_mode    (cont_mode),
        .period       (period),
        .therm_in     (therm_in),
        .sample_en    (sample_en),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist[(cyc + 1) % 1024] <= therm_in;
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int decode_m(input logic [THERM_W-1:0] t);
        logic [THERM_W-1:0] u;
        int n;
        u = t;
`ifdef TIQ_BUBBLE_CORR_EN
        for (int i = 0; i < THERM_W; i++) begin
            int below, above;
            below = (i == 0) ? 1 : int'(t[i-1]);
            above = (i == THERM_W - 1) ? 0 : int'(t[i+1]);
            u[i] = ((below + int'(t[i]) + above) >= 2);
        end
`endif
        n = 0;
        while (n < THERM_W && u[n] == 1'b1) n++;
        return n;
    endfunction

    function automatic int exp_res(input int t0);
        int s;
        s = 0;
        for (int i = 0; i < NAVG; i++) s += decode_m(hist[(t0 + WIN + i) % 1024]);
        return s / NAVG;
    endfunction

    function automatic logic [THERM_W-1:0] rand_therm();
        logic [THERM_W-1:0] p;
        int n;
        n = $urandom_range(0, THERM_W);
        p = '0;
        for (int i = 0; i < n; i++) p[i] = 1'b1;
        if ($urandom_range(0, 2) == 0) p[$urandom_range(0, THERM_W - 1)] ^= 1'b1;
        return p;
    endfunction

    // One single-shot conversion; odd edges after T see pb, even edges see pa.
    task automatic convert(input string tag, input logic [THERM_W-1:0] pa,
                           input logic [THERM_W-1:0] pb, input int exp_const);
        int t0;
        therm_in = pa;
        start    = 1'b1;
        tick();
        start = 1'b0;
        t0    = cyc;
        chk({tag, "_busy_T"}, busy, 1);
        chk({tag, "_sample_en_T"}, sample_en, 1);
        for (int k = 1; k <= LAT; k++) begin
            therm_in = (k % 2 == 1) ? pb : pa;
            tick();
            if (k < LAT) begin
                chk($sformatf("%s_busy_k%0d", tag, k), busy, 1);
                chk($sformatf("%s_sample_en_k%0d", tag, k), sample_en, 1);
                if (k > 1) chk($sformatf("%s_novalid_k%0d", tag, k), result_valid, 0);
            end else begin
                chk({tag, "_valid"}, result_valid, 1);
                chk({tag, "_busy_done"}, busy, 0);
                chk({tag, "_sample_en_done"}, sample_en, 0);
                chk({tag, "_result_model"}, result, exp_res(t0));
                if (exp_const >= 0) chk({tag, "_result_const"}, result, exp_const);
            end
        end
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, "_hs_valid"}, result_valid, 0);
        chk({tag, "_hs_overrun"}, overrun, 0);
    endtask

    initial begin
        int t0;
        bit m_valid, m_over, rdy, is_done;
        int m_res;

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont_mode = 1'b0;
        result_ready = 1'b0; period = 8'd0; therm_in = '0;
        tick();
        tick();
        chk("rst_sample_en", sample_en, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        convert("t1", 15'h00FF, 15'h00FF, 8);
        handshake("t1");
        convert("t2", 15'h002F, 15'h002F, EXP_BUBB);
        handshake("t2");
        convert("t3", 15'h0007, 15'h000F, 3);
        handshake("t3");
        for (int r = 0; r < 4; r++) begin
            convert($sformatf("rnd%0d", r), rand_therm(), rand_therm(), -1);
            handshake($sformatf("rnd%0d", r));
        end

        // Free-running mode with a handshake model.
        period = 8'(PER); result_ready = 1'b1; cont_mode = 1'b1;
        therm_in = rand_therm();
        tick();
        t0 = cyc;
        m_valid = 0; m_over = 0; m_res = 0;
        for (int k = 1; k <= 5 * SPAN + LAT + 3; k++) begin
            therm_in = rand_therm();
            if (k == 3 * SPAN) result_ready = 1'b0;
            if (k == 4 * SPAN + LAT + 1) result_ready = 1'b1;
            if (k == 5 * SPAN + 3) cont_mode = 1'b0;
            rdy = result_ready;
            tick();
            is_done = (k >= LAT) && ((k - LAT) % SPAN == 0) && ((k - LAT) / SPAN <= 5);
            if (is_done) begin
                if (m_valid && !rdy) m_over = 1;
                m_valid = 1;
                m_res   = exp_res(t0 + (k - LAT));
            end else if (m_valid && rdy) begin
                m_valid = 0;
                m_over  = 0;
            end
            chk($sformatf("cont_valid_k%0d", k), result_valid, m_valid);
            chk($sformatf("cont_overrun_k%0d", k), overrun, m_over);
            chk($sformatf("cont_busy_k%0d", k), busy, (k < 5 * SPAN + LAT) ? 1 : 0);
            if (m_valid) chk($sformatf("cont_result_k%0d", k), result, m_res);
            if (k == 4 * SPAN + LAT) chk("cont_overrun_set", overrun, 1);
        end
        result_ready = 1'b0;

        // Abort during ACC with an unread result pending.
        convert("t5a", rand_therm(), rand_therm(), -1);
        therm_in = 15'h7FFF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= LAT - NAVG; k++) tick();
        chk("t5_in_acc_busy", busy, 1);
        ena = 1'b0;
        tick();
        chk("t5_abort_sample_en", sample_en, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_valid", result_valid, 0);
        chk("t5_abort_overrun", overrun, 0);
        ena = 1'b1;
        tick();
        convert("t5b", 15'h0003, 15'h0003, 2);

        // Asynchronous reset while in SETTLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_pre_sample_en", sample_en, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sample_en", sample_en, 0);
        chk("t6_rst_result", result, 0);
        chk("t6_rst_valid", result_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_overrun", overrun, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_busy", busy, 0);
        convert("t6_full", 15'h7FFF, 15'h7FFF, 15);
        handshake("t6_full");
        convert("t6_zero", 15'h0000, 15'h0000, 0);
        handshake("t6_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
